// File: rtl/windowed_watchdog_pkg.sv
// Shared constants, failure codes and unlock-FSM state type for the windowed watchdog.
package windowed_watchdog_pkg;
  localparam logic [15:0] KEY1      = 16'hAAAA;
  localparam logic [15:0] KEY2      = 16'h5555;
  localparam int          WR_CYCLES = 4;
  localparam logic [19:0] BO_THRESH = 20'h0F000;

  localparam logic [2:0] ADDR_FRAME   = 3'b000;
  localparam logic [2:0] ADDR_SERVICE = 3'b001;
  localparam logic [2:0] ADDR_CTRL    = 3'b010;
  localparam logic [2:0] ADDR_RLIMIT  = 3'b011;

  localparam int INIT_BIT = 4;
  localparam int KICK_BIT = 3;

  localparam logic [2:0] FL_NONE     = 3'b000;
  localparam logic [2:0] FL_TIMEOUT  = 3'b001;
  localparam logic [2:0] FL_BADSVC   = 3'b010;
  localparam logic [2:0] FL_BROWNOUT = 3'b100;

  typedef enum logic [1:0] {ST_LOCKED, ST_KEY1_SEEN, ST_OPEN} unlock_state_e;
endpackage

// File: rtl/windowed_watchdog_top_unlock.sv
// Key-sequence detector: KEY1 then KEY2 opens a fixed number of bus write cycles.
module wd_unlock_fsm #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] KEY1      = windowed_watchdog_pkg::KEY1,
  parameter logic [DATA_W-1:0] KEY2      = windowed_watchdog_pkg::KEY2,
  parameter int                WR_CYCLES = windowed_watchdog_pkg::WR_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] dbus_i,
  output logic              wr_en_o
);
  import windowed_watchdog_pkg::*;

  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WR_CYCLES - 1);

  unlock_state_e state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_LOCKED;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Key words are plain data while the window is open.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wr_en_o = 1'b0;
    case (state_q)
      ST_LOCKED:    if (dbus_i == KEY1) state_d = ST_KEY1_SEEN;
      ST_KEY1_SEEN: begin
        if (dbus_i == KEY2) begin
          state_d = ST_OPEN;
          wcnt_d  = '0;
        end else if (dbus_i != KEY1) begin
          state_d = ST_LOCKED;
        end
      end
      ST_OPEN: begin
        wr_en_o = 1'b1;
        wcnt_d  = wcnt_q + 1'b1;
        if (wcnt_q == LAST) state_d = ST_LOCKED;
      end
      default: state_d = ST_LOCKED;
    endcase
  end
endmodule

// File: rtl/windowed_watchdog_top.sv
// Windowed watchdog: config registers, frame counter, failure latch, reset countdown, brownout.
module windowed_watchdog_top #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 3,
  parameter int                ADC_W     = 20,
  parameter logic [DATA_W-1:0] KEY1      = windowed_watchdog_pkg::KEY1,
  parameter logic [DATA_W-1:0] KEY2      = windowed_watchdog_pkg::KEY2,
  parameter int                WR_CYCLES = windowed_watchdog_pkg::WR_CYCLES,
  parameter logic [ADC_W-1:0]  BO_THRESH = windowed_watchdog_pkg::BO_THRESH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ABUS,
  input  logic [DATA_W-1:0] DBUS,
  input  logic [ADC_W-1:0]  ADC_IN,
  output logic              RSTOUT,
  output logic              WDFAIL,
  output logic [2:0]        FLSTAT,
  output logic              BROWNOUT
);
  import windowed_watchdog_pkg::*;

  logic wr_en;

  wd_unlock_fsm #(.DATA_W(DATA_W), .KEY1(KEY1), .KEY2(KEY2), .WR_CYCLES(WR_CYCLES)) u_unlock (
    .clk_i  (CLK),
    .rst_ni (RST),
    .dbus_i (DBUS),
    .wr_en_o(wr_en)
  );

  logic [DATA_W-1:0] frame_len_q, svc_len_q, rlimit_q;
  logic [DATA_W-1:0] fcnt_q, fcnt_d, dcnt_q, dcnt_d;
  logic              en_q, en_d, cd_q, cd_d, rstout_q, rstout_d, wdfail_q, wdfail_d;
  logic              bo_q, bo_prev_q;
  logic [2:0]        flstat_q, flstat_d, fail_code;
  logic              ctrl_wr, init_go, kick, kick_ok, last, open_win, cfg_ok;

  assign ctrl_wr  = wr_en && (ABUS == ADDR_CTRL);
  assign cfg_ok   = (frame_len_q != '0) && (svc_len_q <= frame_len_q);
  assign init_go  = ctrl_wr && DBUS[INIT_BIT] && !cd_q && cfg_ok;
  assign kick     = ctrl_wr && DBUS[KICK_BIT] && !DBUS[INIT_BIT];
  assign last     = (fcnt_q == frame_len_q - 1'b1);
  // The last frame cycle counts as open even when SERVICE_LEN is zero.
  assign open_win = (fcnt_q >= frame_len_q - svc_len_q) || last;
  assign kick_ok  = en_q && kick && open_win && !init_go;

  always_comb begin
    fail_code = FL_NONE;
    if (en_q && !init_go && !kick_ok) begin
      if (last)                   fail_code = FL_TIMEOUT;
      else if (kick)              fail_code = FL_BADSVC;
      else if (bo_q && !bo_prev_q) fail_code = FL_BROWNOUT;
    end
  end

  always_comb begin
    en_d     = en_q;
    fcnt_d   = en_q ? fcnt_q + 1'b1 : fcnt_q;
    cd_d     = cd_q;
    dcnt_d   = dcnt_q;
    rstout_d = 1'b0;
    wdfail_d = wdfail_q;
    flstat_d = flstat_q;
    if (cd_q) begin
      if (dcnt_q == '0) begin
        cd_d     = 1'b0;
        rstout_d = 1'b1;
      end else begin
        dcnt_d = dcnt_q - 1'b1;
      end
    end
    if (init_go) begin
      en_d     = 1'b1;
      fcnt_d   = '0;
      wdfail_d = 1'b0;
      flstat_d = FL_NONE;
    end else if (kick_ok) begin
      fcnt_d = '0;
    end else if (fail_code != FL_NONE) begin
      en_d     = 1'b0;
      wdfail_d = 1'b1;
      flstat_d = fail_code;
      cd_d     = 1'b1;
      dcnt_d   = rlimit_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_len_q <= '0;
      svc_len_q   <= '0;
      rlimit_q    <= '0;
      fcnt_q      <= '0;
      dcnt_q      <= '0;
      en_q        <= 1'b0;
      cd_q        <= 1'b0;
      rstout_q    <= 1'b0;
      wdfail_q    <= 1'b0;
      flstat_q    <= FL_NONE;
      bo_q        <= 1'b0;
      bo_prev_q   <= 1'b0;
    end else begin
      if (wr_en && ABUS == ADDR_FRAME)   frame_len_q <= DBUS;
      if (wr_en && ABUS == ADDR_SERVICE) svc_len_q   <= DBUS;
      if (wr_en && ABUS == ADDR_RLIMIT)  rlimit_q    <= DBUS;
      fcnt_q    <= fcnt_d;
      dcnt_q    <= dcnt_d;
      en_q      <= en_d;
      cd_q      <= cd_d;
      rstout_q  <= rstout_d;
      wdfail_q  <= wdfail_d;
      flstat_q  <= flstat_d;
      bo_q      <= (ADC_IN < BO_THRESH);
      bo_prev_q <= bo_q;
    end
  end

  assign RSTOUT   = rstout_q;
  assign WDFAIL   = wdfail_q;
  assign FLSTAT   = flstat_q;
  assign BROWNOUT = bo_q;
endmodule

// File: tb/tb_windowed_watchdog_top.sv
// Randomized bench for windowed_watchdog_top against an edge-count based reference model.
module tb_windowed_watchdog_top;
  localparam logic [15:0] K1 = 16'hAAAA;
  localparam logic [15:0] K2 = 16'h5555;
  localparam int TH = 'h0F000;

  logic CLK = 1'b0, RST = 1'b0;
  logic [2:0] ABUS = '0;
  logic [15:0] DBUS = '0;
  logic [19:0] ADC_IN = 20'hFFFFF;
  logic RSTOUT, WDFAIL, BROWNOUT;
  logic [2:0] FLSTAT;

  always #5 CLK = ~CLK;

  windowed_watchdog_top dut (
    .CLK(CLK), .RST(RST), .ABUS(ABUS), .DBUS(DBUS), .ADC_IN(ADC_IN),
    .RSTOUT(RSTOUT), .WDFAIL(WDFAIL), .FLSTAT(FLSTAT), .BROWNOUT(BROWNOUT)
  );

  int checks = 0, failures = 0;

  // Model: time is the count of clock edges; a frame is "edges since its start".
  int ecnt = 0, m_start = 0, m_rst_edge = -1, m_wleft = 0, m_flstat = 0;
  int m_fl = 0, m_sl = 0, m_rl = 0;
  bit m_k1, m_en, m_wdfail, m_bo, m_bo_old;
  logic [19:0] adc = 20'hFFFFF;

  function automatic logic [5:0] dut_out();
    return {RSTOUT, WDFAIL, FLSTAT, BROWNOUT};
  endfunction
  function automatic logic [5:0] exp_out();
    return {ecnt == m_rst_edge, m_wdfail, 3'(m_flstat), m_bo};
  endfunction
  function automatic int cur_fc();
    return ecnt - m_start;
  endfunction

  task automatic model_reset();
    m_wleft = 0; m_k1 = 0; m_en = 0; m_wdfail = 0; m_flstat = 0; m_rst_edge = -1;
    m_bo = 0; m_bo_old = 0; m_fl = 0; m_sl = 0; m_rl = 0;
  endtask

  task automatic model_edge(input logic [2:0] a, input logic [15:0] d, input logic [19:0] v);
    int fc, code;
    bit wr, init, kick, open_w, busy;
    ecnt++;
    wr = m_wleft > 0;
    if (m_wleft > 0) m_wleft--;
    else if (m_k1 && d == K2) begin m_wleft = 4; m_k1 = 0; end
    else m_k1 = (d == K1);
    init = wr && a == 3'd2 && d[4];
    kick = wr && a == 3'd2 && d[3] && !d[4];
    busy = m_rst_edge >= ecnt;
    fc = ecnt - 1 - m_start;
    code = 0;
    if (init && !busy && m_fl != 0 && m_sl <= m_fl) begin
      m_en = 1; m_start = ecnt; m_wdfail = 0; m_flstat = 0;
    end else if (m_en) begin
      open_w = (fc >= m_fl - m_sl) || (fc == m_fl - 1);
      if (kick && open_w) m_start = ecnt;
      else if (fc == m_fl - 1) code = 1;
      else if (kick) code = 2;
      else if (m_bo && !m_bo_old) code = 4;
      if (code != 0) begin
        m_en = 0; m_wdfail = 1; m_flstat = code; m_rst_edge = ecnt + m_rl + 1;
      end
    end
    if (wr) case (a)
      3'd0: m_fl = int'(d);
      3'd1: m_sl = int'(d);
      3'd3: m_rl = int'(d);
      default: ;
    endcase
    m_bo_old = m_bo;
    m_bo = int'(v) < TH;
  endtask

  task automatic step(input logic [2:0] a, input logic [15:0] d);
    ABUS = a; DBUS = d; ADC_IN = adc;
    @(posedge CLK);
    model_edge(a, d, adc);
    @(negedge CLK);
  endtask

  // Unlock, three idle writes, then INIT as the last write so the bus relocks at fcnt=0.
  task automatic do_init();
    step(3'd4, K1); step(3'd4, K2);
    for (int i = 0; i < 3; i++) step(3'd4, 16'h0);
    step(3'd2, 16'h0010);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (dut_out() !== 6'b0) begin failures++; $display("FAIL reset: got %b expected 000000", dut_out()); end
    model_reset();
    RST = 1'b1;
    step(3'd4, 16'h0);
    checks++;
    if (dut_out() !== exp_out()) begin failures++; $display("FAIL reset_idle: got %b expected %b", dut_out(), exp_out()); end
  endtask

  task automatic test_config();
    logic [15:0] w[6] = '{16'h3636, 16'h1111, K1, K1, K1, K2};
    logic [2:0]  wa[4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [15:0] wd[4] = '{16'h000A, 16'h0003, 16'h0004, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      if (i < 6) step(3'd4, w[i]); else step(wa[i-6], wd[i-6]);
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL config[%0d]: got %b expected %b", i, dut_out(), exp_out()); end
    end
  endtask

  task automatic test_bad_unlock();
    logic [15:0] w[3] = '{K1, 16'h1234, K2};
    for (int i = 0; i < 3; i++) step(3'd4, w[i]);
    step(3'd0, 16'h0020);
    step(3'd4, K1); step(3'd4, K2);
    for (int i = 0; i < 4; i++) step(3'd4, 16'h0);
    step(3'd0, 16'h0020);
    checks++;
    if (dut_out() !== exp_out()) begin failures++; $display("FAIL bad_unlock: got %b expected %b", dut_out(), exp_out()); end
    // SERVICE_LEN > FRAME_LEN makes INIT a no-op.
    step(3'd4, K1); step(3'd4, K2);
    step(3'd1, 16'h000B); step(3'd2, 16'h0010); step(3'd1, 16'h0003); step(3'd4, 16'h0);
    for (int i = 0; i < 15; i++) begin
      step(3'd4, 16'h0);
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL init_ignored[%0d]: got %b expected %b", i, dut_out(), exp_out()); end
    end
  endtask

  task automatic test_timeout();
    int ie, wd_e = -1, rs_e = -1;
    do_init();
    ie = ecnt;
    for (int i = 0; i < 30; i++) begin
      step(3'd4, 16'h0);
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL timeout[%0d]: got %b expected %b", i, dut_out(), exp_out()); end
      if (WDFAIL === 1'b1 && wd_e < 0) begin
        wd_e = ecnt;
        checks++;
        if (FLSTAT !== 3'b001) begin failures++; $display("FAIL timeout_code: got %b expected 001", FLSTAT); end
      end
      if (RSTOUT === 1'b1 && rs_e < 0) rs_e = ecnt;
    end
    checks++;
    if (wd_e - ie !== 10) begin failures++; $display("FAIL timeout_cycles: got %0d expected 10", wd_e - ie); end
    checks++;
    if (rs_e - wd_e !== 5) begin failures++; $display("FAIL rstout_delay: got %0d expected 5", rs_e - wd_e); end
  endtask

  task automatic test_double_kick();
    do_init();
    for (int i = 0; i < 20 && cur_fc() != 6; i++) step(3'd4, 16'h0);
    step(3'd4, K1); step(3'd4, K2);
    step(3'd2, 16'h0008); step(3'd4, 16'h0); step(3'd2, 16'h0008);
    checks++;
    if (FLSTAT !== 3'b010 || WDFAIL !== 1'b1) begin failures++; $display("FAIL double_kick: got %b/%b expected 1/010", WDFAIL, FLSTAT); end
    for (int i = 0; i < 10; i++) begin
      step(3'd4, 16'h0);
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL double_kick[%0d]: got %b expected %b", i, dut_out(), exp_out()); end
    end
  endtask

  task automatic test_kicks();
    int k;
    do_init();
    for (int f = 0; f < 5; f++) begin
      k = int'($urandom_range(9, 7));
      for (int i = 0; i < 20 && !(cur_fc() == k - 5 && m_wleft == 0); i++) begin
        adc = 20'($urandom_range(20'hFFFFF, 20'h0F000));
        step(3'd4, 16'h0);
      end
      step(3'd4, K1); step(3'd4, K2);
      for (int i = 0; i < 3; i++) step(3'd4, 16'h0);
      step(3'd2, 16'h0008);
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL kick_frame%0d(k=%0d): got %b expected %b", f, k, dut_out(), exp_out()); end
    end
    checks++;
    if (WDFAIL !== 1'b0 || RSTOUT !== 1'b0) begin failures++; $display("FAIL kicks_clean: got %b/%b expected 0/0", WDFAIL, RSTOUT); end
    step(3'd4, 16'h0);
    step(3'd4, K1); step(3'd4, K2);
    step(3'd2, 16'h0008);
    checks++;
    if (FLSTAT !== 3'b010) begin failures++; $display("FAIL early_kick: got %b expected 010", FLSTAT); end
    for (int i = 0; i < 10; i++) begin
      step(3'd4, 16'h0);
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL early_kick[%0d]: got %b expected %b", i, dut_out(), exp_out()); end
    end
  endtask

  task automatic test_brownout();
    adc = 20'hFFFFF;
    do_init();
    step(3'd4, 16'h0); step(3'd4, 16'h0);
    adc = 20'h00100;
    step(3'd4, 16'h0);
    checks++;
    if (BROWNOUT !== 1'b1 || WDFAIL !== 1'b0) begin failures++; $display("FAIL brownout_flag: got %b/%b expected 1/0", BROWNOUT, WDFAIL); end
    step(3'd4, 16'h0);
    checks++;
    if (FLSTAT !== 3'b100 || WDFAIL !== 1'b1) begin failures++; $display("FAIL brownout_code: got %b/%b expected 1/100", WDFAIL, FLSTAT); end
    step(3'd4, 16'h0); step(3'd4, 16'h0);
    RST = 1'b0;
    #1;
    checks++;
    if (dut_out() !== 6'b0) begin failures++; $display("FAIL reset_midcount: got %b expected 000000", dut_out()); end
    model_reset();
    adc = 20'hFFFFF;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(3'd4, 16'h0);
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL post_reset[%0d]: got %b expected %b", i, dut_out(), exp_out()); end
    end
  endtask

  task automatic test_rlimit0();
    int ie, wd_e = -1, rs_e = -1;
    step(3'd4, K1); step(3'd4, K2);
    step(3'd0, 16'h0004); step(3'd1, 16'h0002); step(3'd3, 16'h0000); step(3'd4, 16'h0);
    do_init();
    ie = ecnt;
    for (int i = 0; i < 12; i++) begin
      step(3'd4, 16'h0);
      checks++;
      if (dut_out() !== exp_out()) begin failures++; $display("FAIL rlimit0[%0d]: got %b expected %b", i, dut_out(), exp_out()); end
      if (WDFAIL === 1'b1 && wd_e < 0) wd_e = ecnt;
      if (RSTOUT === 1'b1 && rs_e < 0) rs_e = ecnt;
    end
    checks++;
    if (wd_e - ie !== 4) begin failures++; $display("FAIL rlimit0_timeout: got %0d expected 4", wd_e - ie); end
    checks++;
    if (rs_e - wd_e !== 1) begin failures++; $display("FAIL rlimit0_rstout: got %0d expected 1", rs_e - wd_e); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_config();
    test_bad_unlock();
    test_timeout();
    test_double_kick();
    test_kicks();
    test_brownout();
    test_rlimit0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
